// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader sitting in front of the multi-cycle CPU controller.
//   Accepts a byte stream made of a 16-bit big-endian length header followed
//   by the program image. The image is written into memory starting at
//   BASE_ADDR while the CPU is held in reset. Afterwards the CPU is released
//   and a high-then-low `start` sequence walks the controller from IDLE
//   through START to FETCH.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   inValid/inData    byte stream input
//   inReady           loader can take a byte (transfer = inValid && inReady)
//   memAddr           registered write address
//   memWriteData      registered write data
//   memWriteEn        registered one-cycle write strobe
//   memOwn            1 = memory port belongs to the loader, 0 = CPU datapath
//   cpuRst            reset for the controller/datapath
//   start             start pulse to the controller
//   cpuDone           controller `done` (high only while it sits in IDLE)
//   launched          CPU running, sticky until rst
//   errOverflow       header length exceeded capacity, sticky until rst
module program_loader #(
  parameter int ADDR_W       = 13,
  parameter int BASE_ADDR    = 0,
  parameter int START_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  input  logic [7:0]        inData,
  output logic              inReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memWriteData,
  output logic              memWriteEn,
  output logic              memOwn,
  output logic              cpuRst,
  output logic              start,
  input  logic              cpuDone,
  output logic              launched,
  output logic              errOverflow
);

  typedef enum logic [2:0] {
    HDR_HI   = 3'd0,
    HDR_LO   = 3'd1,
    LOAD     = 3'd2,
    START_HI = 3'd3,
    START_LO = 3'd4,
    RUN      = 3'd5,
    ERR      = 3'd6
  } state_t;

  // Capacity of the region from BASE_ADDR to the top of the address space.
  localparam int unsigned       DEPTH      = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [15:0]       START_LAST = 16'(START_CYCLES - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [7:0]          len_hi_r;
  logic [15:0]         remaining_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic [15:0]         cnt_r;
  logic                xfer_s;
  logic [15:0]         len_full_s;

  assign xfer_s     = inValid & inReady;
  assign len_full_s = {len_hi_r, inData};

  // Next-state decode; outputs are registered from this value so that they
  // change on the same edge as the state itself.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HDR_HI: begin
        if (xfer_s) state_nxt_s = HDR_LO;
        else        state_nxt_s = HDR_HI;
      end
      HDR_LO: begin
        if (xfer_s) begin
          if (len_full_s == 16'd0)                 state_nxt_s = START_HI;
          else if ({16'd0, len_full_s} > DEPTH)    state_nxt_s = ERR;
          else                                     state_nxt_s = LOAD;
        end else begin
          state_nxt_s = HDR_LO;
        end
      end
      LOAD: begin
        if (xfer_s && (remaining_r == 16'd1)) state_nxt_s = START_HI;
        else                                  state_nxt_s = LOAD;
      end
      START_HI: begin
        if (cnt_r == START_LAST) state_nxt_s = START_LO;
        else                     state_nxt_s = START_HI;
      end
      START_LO: begin
        if (!cpuDone) state_nxt_s = RUN;
        else          state_nxt_s = START_LO;
      end
      RUN:     state_nxt_s = RUN;
      ERR:     state_nxt_s = ERR;
      default: state_nxt_s = HDR_HI;
    endcase
  end

  // Loader FSM: state, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= HDR_HI;
      len_hi_r     <= 8'd0;
      remaining_r  <= 16'd0;
      ptr_r        <= BASE;
      cnt_r        <= 16'd0;
      memAddr      <= BASE;
      memWriteData <= 8'd0;
      memWriteEn   <= 1'b0;
      inReady      <= 1'b0;
      memOwn       <= 1'b1;
      cpuRst       <= 1'b1;
      start        <= 1'b0;
      launched     <= 1'b0;
      errOverflow  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;

      if ((state_r == HDR_HI) && xfer_s) len_hi_r <= inData;
      else                               len_hi_r <= len_hi_r;

      // Image write: strobe is only ever a single cycle wide.
      if ((state_r == LOAD) && xfer_s) begin
        memWriteData <= inData;
        memWriteEn   <= 1'b1;
        memAddr      <= ptr_r;
        ptr_r        <= ptr_r + ADDR_W'(1);
        remaining_r  <= remaining_r - 16'd1;
      end else begin
        memWriteEn <= 1'b0;
        if ((state_r == HDR_LO) && xfer_s) remaining_r <= len_full_s;
        else                               remaining_r <= remaining_r;
      end

      // Counts cycles already spent in START_HI; cleared everywhere else.
      if (state_r == START_HI) cnt_r <= cnt_r + 16'd1;
      else                     cnt_r <= 16'd0;

      inReady     <= (state_nxt_s == HDR_HI) || (state_nxt_s == HDR_LO) ||
                     (state_nxt_s == LOAD);
      // START_HI keeps the port so the final image write still lands.
      memOwn      <= (state_nxt_s != START_LO) && (state_nxt_s != RUN);
      cpuRst      <= (state_nxt_s == HDR_HI) || (state_nxt_s == HDR_LO) ||
                     (state_nxt_s == LOAD)   || (state_nxt_s == ERR);
      start       <= (state_nxt_s == START_HI);
      launched    <= (state_nxt_s == RUN);
      errOverflow <= (state_nxt_s == ERR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: one default instance (ADDR_W=13,
// BASE_ADDR=0) and one small instance (ADDR_W=4, BASE_ADDR=2) for capacity
// boundary checks. Inputs are driven on the falling edge, outputs sampled there.
module tb_program_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, in_valid1, in_ready1, mem_we1, mem_own1, cpu_rst1, start1, cpu_done1, launched1, err1;
  logic [7:0]  in_data1, mem_wd1;
  logic [12:0] mem_addr1;
  logic        rst2, in_valid2, in_ready2, mem_we2, mem_own2, cpu_rst2, start2, cpu_done2, launched2, err2;
  logic [7:0]  in_data2, mem_wd2;
  logic [3:0]  mem_addr2;

  program_loader #(.ADDR_W(13), .BASE_ADDR(0), .START_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst1), .inValid(in_valid1), .inData(in_data1), .inReady(in_ready1),
    .memAddr(mem_addr1), .memWriteData(mem_wd1), .memWriteEn(mem_we1), .memOwn(mem_own1),
    .cpuRst(cpu_rst1), .start(start1), .cpuDone(cpu_done1), .launched(launched1),
    .errOverflow(err1));

  program_loader #(.ADDR_W(4), .BASE_ADDR(2), .START_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .inValid(in_valid2), .inData(in_data2), .inReady(in_ready2),
    .memAddr(mem_addr2), .memWriteData(mem_wd2), .memWriteEn(mem_we2), .memOwn(mem_own2),
    .cpuRst(cpu_rst2), .start(start2), .cpuDone(cpu_done2), .launched(launched2),
    .errOverflow(err2));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory-side write logs (what a memory would capture on each edge).
  int         log_cyc1[$];
  logic [12:0] log_addr1[$];
  logic [7:0] log_data1[$];
  logic [3:0] log_addr2[$];
  logic [7:0] log_data2[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we1 === 1'b1) begin
      log_cyc1.push_back(cyc); log_addr1.push_back(mem_addr1); log_data1.push_back(mem_wd1);
    end
    if (mem_we2 === 1'b1) begin
      log_addr2.push_back(mem_addr2); log_data2.push_back(mem_wd2);
    end
  end

  logic [7:0] stim [0:31];
  int         stim_n;

  // Drive stim[0..stim_n-1]; returns on the falling edge right after the last byte's rising edge.
  task automatic feed(input int which, input bit gap);
    for (int i = 0; i < stim_n; i++) begin
      @(negedge clk);
      if (which == 1) begin in_valid1 = 1'b1; in_data1 = stim[i]; end
      else            begin in_valid2 = 1'b1; in_data2 = stim[i]; end
      if (gap) begin
        @(negedge clk);
        if (which == 1) begin in_valid1 = 1'b0; in_data1 = 8'hEE; end
        else            begin in_valid2 = 1'b0; in_data2 = 8'hEE; end
      end
    end
    if (!gap) begin
      @(negedge clk);
      if (which == 1) in_valid1 = 1'b0;
      else            in_valid2 = 1'b0;
    end
  endtask

  task automatic reset1();
    @(negedge clk); rst1 = 1'b1; in_valid1 = 1'b0; cpu_done1 = 1'b1;
    @(negedge clk); rst1 = 1'b0;
    @(negedge clk);
    log_cyc1.delete(); log_addr1.delete(); log_data1.delete();
  endtask

  task automatic reset2();
    @(negedge clk); rst2 = 1'b1; in_valid2 = 1'b0; cpu_done2 = 1'b1;
    @(negedge clk); rst2 = 1'b0;
    @(negedge clk);
    log_addr2.delete(); log_data2.delete();
  endtask

  task automatic wait_launch1(input string name);
    int k;
    k = 0;
    while (launched1 !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    n_checks++; if (launched1 !== 1'b1) begin n_fail++; $display("FAIL %s_launch: launched=%b want 1 (timeout)", name, launched1); end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_data1 = 8'h00; in_data2 = 8'h00; cpu_done1 = 1'b1; cpu_done2 = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL rst_inReady: got %b want 0", in_ready1); end
    n_checks++; if ({mem_we1, mem_own1, cpu_rst1, start1, launched1, err1} !== 6'b011000) begin n_fail++; $display("FAIL rst_flags: got %b want 011000", {mem_we1, mem_own1, cpu_rst1, start1, launched1, err1}); end
    n_checks++; if (mem_addr1 !== 13'd0 || mem_wd1 !== 8'h00) begin n_fail++; $display("FAIL rst_addr_data: got %h/%h want 0000/00", mem_addr1, mem_wd1); end
    n_checks++; if (mem_addr2 !== 4'd2) begin n_fail++; $display("FAIL rst_base_addr: got %0d want 2", mem_addr2); end
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b%b want 11", in_ready1, in_ready2); end
    n_checks++; if (cpu_rst1 !== 1'b1 || mem_own1 !== 1'b1) begin n_fail++; $display("FAIL rst_release_hold: got %b%b want 11", cpu_rst1, mem_own1); end
  endtask

  task automatic test_back_to_back();
    reset1();
    stim[0] = 8'h00; stim[1] = 8'h03; stim[2] = 8'hA0; stim[3] = 8'hB1; stim[4] = 8'hC2; stim_n = 5;
    feed(1, 1'b0);
    n_checks++; if (mem_we1 !== 1'b1 || mem_addr1 !== 13'd2 || mem_wd1 !== 8'hC2) begin n_fail++; $display("FAIL b2b_last_write: got we=%b a=%0d d=%h want 1/2/C2", mem_we1, mem_addr1, mem_wd1); end
    n_checks++; if ({start1, cpu_rst1, mem_own1, in_ready1} !== 4'b1010) begin n_fail++; $display("FAIL b2b_start_rise: got %b want 1010", {start1, cpu_rst1, mem_own1, in_ready1}); end
    @(negedge clk);
    n_checks++; if (start1 !== 1'b1 || mem_we1 !== 1'b0) begin n_fail++; $display("FAIL b2b_start_2nd: got start=%b we=%b want 1/0", start1, mem_we1); end
    @(negedge clk);
    n_checks++; if ({start1, mem_own1, launched1} !== 3'b000) begin n_fail++; $display("FAIL b2b_start_lo: got %b want 000", {start1, mem_own1, launched1}); end
    cpu_done1 = 1'b0;
    @(negedge clk);
    n_checks++; if ({launched1, mem_own1, cpu_rst1, in_ready1} !== 4'b1000) begin n_fail++; $display("FAIL b2b_run: got %b want 1000", {launched1, mem_own1, cpu_rst1, in_ready1}); end
    n_checks++; if (log_addr1.size() != 3) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 3", log_addr1.size()); end
    else begin
      n_checks++; if (log_addr1[0] !== 13'd0 || log_addr1[1] !== 13'd1 || log_addr1[2] !== 13'd2) begin n_fail++; $display("FAIL b2b_addrs: got %0d,%0d,%0d want 0,1,2", log_addr1[0], log_addr1[1], log_addr1[2]); end
      n_checks++; if (log_data1[0] !== 8'hA0 || log_data1[1] !== 8'hB1 || log_data1[2] !== 8'hC2) begin n_fail++; $display("FAIL b2b_data: got %h,%h,%h want A0,B1,C2", log_data1[0], log_data1[1], log_data1[2]); end
      n_checks++; if (log_cyc1[1] != log_cyc1[0] + 1 || log_cyc1[2] != log_cyc1[0] + 2) begin n_fail++; $display("FAIL b2b_consecutive: got cycles %0d,%0d,%0d want consecutive", log_cyc1[0], log_cyc1[1], log_cyc1[2]); end
    end
  endtask

  task automatic test_gapped();
    reset1();
    stim[0] = 8'h00; stim[1] = 8'h03; stim[2] = 8'hA0; stim[3] = 8'hB1; stim[4] = 8'hC2; stim_n = 5;
    feed(1, 1'b1);
    cpu_done1 = 1'b0;
    wait_launch1("gap");
    n_checks++; if (log_addr1.size() != 3) begin n_fail++; $display("FAIL gap_nwrites: got %0d want 3", log_addr1.size()); end
    else begin
      n_checks++; if (log_addr1[0] !== 13'd0 || log_addr1[1] !== 13'd1 || log_addr1[2] !== 13'd2) begin n_fail++; $display("FAIL gap_addrs: got %0d,%0d,%0d want 0,1,2", log_addr1[0], log_addr1[1], log_addr1[2]); end
      n_checks++; if (log_data1[0] !== 8'hA0 || log_data1[1] !== 8'hB1 || log_data1[2] !== 8'hC2) begin n_fail++; $display("FAIL gap_data: got %h,%h,%h want A0,B1,C2", log_data1[0], log_data1[1], log_data1[2]); end
      n_checks++; if (log_cyc1[1] != log_cyc1[0] + 2 || log_cyc1[2] != log_cyc1[0] + 4) begin n_fail++; $display("FAIL gap_spacing: got cycles %0d,%0d,%0d want step 2", log_cyc1[0], log_cyc1[1], log_cyc1[2]); end
    end
  endtask

  task automatic test_zero_length();
    reset1();
    cpu_done1 = 1'b0;
    stim[0] = 8'h00; stim[1] = 8'h00; stim_n = 2;
    feed(1, 1'b0);
    n_checks++; if ({start1, cpu_rst1, in_ready1} !== 3'b100) begin n_fail++; $display("FAIL zero_start_hi: got %b want 100", {start1, cpu_rst1, in_ready1}); end
    @(negedge clk);
    n_checks++; if (start1 !== 1'b1) begin n_fail++; $display("FAIL zero_start_2nd: got %b want 1", start1); end
    @(negedge clk);
    n_checks++; if (start1 !== 1'b0 || launched1 !== 1'b0) begin n_fail++; $display("FAIL zero_start_lo: got start=%b launched=%b want 0/0", start1, launched1); end
    @(negedge clk);
    n_checks++; if (launched1 !== 1'b1) begin n_fail++; $display("FAIL zero_run: got %b want 1", launched1); end
    n_checks++; if (log_addr1.size() != 0) begin n_fail++; $display("FAIL zero_nwrites: got %0d want 0", log_addr1.size()); end
  endtask

  task automatic test_capacity();
    reset2();
    stim[0] = 8'h00; stim[1] = 8'h0F; stim_n = 2;
    feed(2, 1'b0);
    n_checks++; if ({err2, cpu_rst2, in_ready2, mem_own2, start2} !== 5'b11010) begin n_fail++; $display("FAIL ovf_err: got %b want 11010", {err2, cpu_rst2, in_ready2, mem_own2, start2}); end
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim_n = 3;
    feed(2, 1'b0);
    @(negedge clk);
    n_checks++; if (err2 !== 1'b1 || cpu_rst2 !== 1'b1 || log_addr2.size() != 0) begin n_fail++; $display("FAIL ovf_sticky: got err=%b cpuRst=%b writes=%0d want 1/1/0", err2, cpu_rst2, log_addr2.size()); end
    reset2();
    n_checks++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", err2); end
    cpu_done2 = 1'b0;
    stim[0] = 8'h00; stim[1] = 8'h0E; stim_n = 16;
    for (int i = 0; i < 14; i++) stim[i+2] = 8'h10 + 8'(i);
    feed(2, 1'b0);
    for (int k = 0; k < 60 && launched2 !== 1'b1; k++) @(negedge clk);
    n_checks++; if (launched2 !== 1'b1 || err2 !== 1'b0) begin n_fail++; $display("FAIL full_launch: got launched=%b err=%b want 1/0", launched2, err2); end
    n_checks++; if (log_addr2.size() != 14) begin n_fail++; $display("FAIL full_nwrites: got %0d want 14", log_addr2.size()); end
    else begin
      n_checks++; if (log_addr2[0] !== 4'd2 || log_addr2[13] !== 4'd15) begin n_fail++; $display("FAIL full_addr_range: got %0d..%0d want 2..15", log_addr2[0], log_addr2[13]); end
      n_checks++; if (log_data2[0] !== 8'h10 || log_data2[13] !== 8'h1D) begin n_fail++; $display("FAIL full_data: got %h..%h want 10..1D", log_data2[0], log_data2[13]); end
    end
  endtask

  task automatic test_reset_mid_load();
    reset1();
    stim[0] = 8'h00; stim[1] = 8'h05; stim[2] = 8'h11; stim[3] = 8'h22; stim_n = 4;
    feed(1, 1'b0);
    n_checks++; if (mem_we1 !== 1'b1 || mem_addr1 !== 13'd1 || mem_wd1 !== 8'h22) begin n_fail++; $display("FAIL mid_second_write: got we=%b a=%0d d=%h want 1/1/22", mem_we1, mem_addr1, mem_wd1); end
    rst1 = 1'b1;
    #1;
    n_checks++; if ({mem_we1, mem_own1, cpu_rst1, start1, in_ready1, launched1} !== 6'b011000) begin n_fail++; $display("FAIL mid_async_reset: got %b want 011000", {mem_we1, mem_own1, cpu_rst1, start1, in_ready1, launched1}); end
    n_checks++; if (mem_addr1 !== 13'd0 || mem_wd1 !== 8'h00) begin n_fail++; $display("FAIL mid_reset_addr: got %0d/%h want 0/00", mem_addr1, mem_wd1); end
    @(negedge clk); rst1 = 1'b0;
    @(negedge clk);
    log_cyc1.delete(); log_addr1.delete(); log_data1.delete();
    cpu_done1 = 1'b0;
    stim[0] = 8'h00; stim[1] = 8'h01; stim[2] = 8'h5A; stim_n = 3;
    feed(1, 1'b0);
    wait_launch1("mid");
    n_checks++; if (log_addr1.size() != 1) begin n_fail++; $display("FAIL mid_nwrites: got %0d want 1", log_addr1.size()); end
    else begin
      n_checks++; if (log_addr1[0] !== 13'd0 || log_data1[0] !== 8'h5A) begin n_fail++; $display("FAIL mid_restart_write: got (%0d,%h) want (0,5A)", log_addr1[0], log_data1[0]); end
    end
  endtask

  task automatic test_done_hold();
    reset1();
    stim[0] = 8'h00; stim[1] = 8'h01; stim[2] = 8'h77; stim_n = 3;
    feed(1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if ({start1, launched1, mem_own1, cpu_rst1} !== 4'b0000) begin n_fail++; $display("FAIL hold_start_lo_%0d: got %b want 0000", k, {start1, launched1, mem_own1, cpu_rst1}); end
      @(negedge clk);
    end
    n_checks++; if (launched1 !== 1'b0) begin n_fail++; $display("FAIL hold_not_launched: got %b want 0", launched1); end
    cpu_done1 = 1'b0;
    @(negedge clk);
    n_checks++; if (launched1 !== 1'b1) begin n_fail++; $display("FAIL hold_run: got %b want 1", launched1); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_zero_length();
    test_capacity();
    test_reset_mid_load();
    test_done_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the multi-cycle CPU controller. It accepts a byte stream carrying a 16-bit length header followed by a program image. It writes the image into instruction/data memory from `BASE_ADDR` while holding the CPU in reset. It then releases the CPU and generates the high-then-low `start` sequence that moves the controller from IDLE through START to FETCH.

## Interface
- `ADDR_W`, 13: memory address width.
- `BASE_ADDR`, 0: first address written.
- `START_CYCLES`, 2: cycles `start` is held high (≥1).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `inValid`  in  1  byte available on `inData`.
- `inData`  in  8  stream byte.
- `inReady`  out  1  loader can accept a byte; transfer when `inValid && inReady` at a rising edge.
- `memAddr`  out  ADDR_W  write address, registered.
- `memWriteData`  out  8  write data, registered.
- `memWriteEn`  out  1  one-cycle write strobe, registered.
- `memOwn`  out  1  1 = memory port muxed to loader, 0 = to CPU datapath.
- `cpuRst`  out  1  drives the controller/datapath reset.
- `start`  out  1  to the controller `start` input.
- `cpuDone`  in  1  from the controller `done`; high only while the controller is in IDLE.
- `launched`  out  1  CPU running; sticky until `rst`.
- `errOverflow`  out  1  header length exceeds capacity; sticky until `rst`.

## Operation
- Capacity: `DEPTH = 2^ADDR_W - BASE_ADDR`.
- States:
  - HDR_HI: `inReady=1`. On transfer, `len[15:8] <= inData` → HDR_LO.
  - HDR_LO: `inReady=1`. On transfer, `len[7:0] <= inData`. Evaluate the full 16-bit length:
    - length 0 → START_HI.
    - length > DEPTH → ERR.
    - otherwise → LOAD, with `remaining <= length`.
  - LOAD: `inReady=1`. On each transfer:
    - register `memWriteData <= inData`, `memWriteEn <= 1`, `memAddr <= ptr`.
    - `ptr` increments; `remaining` decrements.
    - the transfer with `remaining == 1` → START_HI.
  - START_HI: `start=1`, `cpuRst=0`, `inReady=0`. Stay exactly `START_CYCLES` cycles, counted by an internal counter → START_LO.
  - START_LO: `start=0`, `memOwn=0`. Go to RUN on the first cycle with `cpuDone==0`; otherwise remain.
  - RUN: `launched=1`, `memOwn=0`, `cpuRst=0`, `inReady=0`. Absorbing state.
  - ERR: `errOverflow=1`, `cpuRst=1`, `inReady=0`, no writes. Absorbing state.
- `memOwn=1` in HDR_HI, HDR_LO, LOAD, START_HI and ERR. The final image write (issued in the first START_HI cycle) therefore still reaches memory.
- `cpuRst=1` in HDR_HI, HDR_LO, LOAD and ERR.
- `memWriteEn` is high only in the cycle after a LOAD transfer; otherwise it is 0.
- Bytes offered with `inValid` while `inReady=0` are ignored, not stalled into later states.
- The address pointer never wraps. The overflow check guarantees the last address is ≤ `2^ADDR_W - 1`.
- Length equal to DEPTH is legal and fills memory through address `2^ADDR_W - 1`.

## Timing
- Reset values (asserted asynchronously):
  - state = HDR_HI.
  - `inReady=0` while `rst` is high; `inReady=1` from the first edge after release.
  - `memAddr=BASE_ADDR`, `memWriteData=0`, `memWriteEn=0`.
  - `memOwn=1`, `cpuRst=1`, `start=0`, `launched=0`, `errOverflow=0`.
- Back-to-back stream of N ≥ 1 payload bytes, with the header-high transfer at edge t0:
  - header-low transfer at t1.
  - payload transfers at t2 … t(N+1).
  - writes visible at t3 … t(N+2).
  - `start` high for cycles t(N+2) … t(N+1+START_CYCLES).
  - START_LO at t(N+2+START_CYCLES); RUN one cycle later when `cpuDone` is already 0.
- Gaps in `inValid` only delay the sequence; no timeout exists.
- `rst` asserted mid-LOAD or mid-START: the sequence aborts immediately to reset values. Memory contents already written are left as-is. The next stream restarts at HDR_HI.
- `cpuRst` drops in the same cycle `start` rises. The controller sees IDLE, then START, then FETCH only after `start` falls and `memOwn=0`.

## Test plan
- Header 0x0003, bytes A0 B1 C2 back-to-back, `BASE_ADDR=0`, `START_CYCLES=2` → writes (0,A0),(1,B1),(2,C2) on consecutive cycles; `start` high 2 cycles; `memOwn` drops with `start`; `launched=1` after `cpuDone` falls.
- Same image with `inValid` toggling every other cycle → identical write sequence with addresses contiguous; no duplicate or dropped bytes.
- Header 0x0000 → no `memWriteEn` pulses; START_HI entered the cycle after header-low; RUN reached.
- `ADDR_W=4`, `BASE_ADDR=2`, header 0x000F → ERR; `errOverflow=1`, `cpuRst` stays 1, `inReady=0`. Header 0x000E → 14 writes, last to address 15, launch.
- `rst` pulsed after the 2nd of 5 payload bytes → outputs return to reset values immediately. A following full stream with header 0x0001, byte 5A writes (0,5A) and launches.
- Hold `cpuDone=1` in START_LO for 4 cycles → loader stays in START_LO with `start=0`, `launched=0`; RUN follows the cycle `cpuDone` drops.
